// File: rtl/tt_um_adder_team11.sv
// Tiny Tapeout tile: registered 8-bit adder/subtractor with optional
// accumulator and unsigned saturation.
//
// Handshake: none. The tile is a plain clocked datapath. Inputs sampled on
// a rising edge with ena = 1 update R and flags, which are visible on the
// outputs after that edge. ena = 0 holds every register.
//
// Control byte uio_in: [0] cin, [1] sub, [2] acc, [3] sat, [7:4] unused.
// Status on uio_out: [4] C, [5] V, [6] Z, [7] N. The low nibble is always 0.
//
// rst_n is active-HIGH despite its name; the name is kept for the tile
// harness. Reset is asynchronous.
module tt_um_adder_team11 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Result and status registers; every output is driven from these.
   logic [7:0] r_result;
   logic       r_c;
   logic       r_v;
   logic       r_z;
   logic       r_n;

   // Decoded controls.
   logic       w_cin;
   logic       w_sub;
   logic       w_acc;
   logic       w_sat;

   // Datapath.
   logic [7:0] w_x;
   logic [7:0] w_y;
   logic [8:0] w_sum;
   logic [7:0] w_raw;
   logic       w_c;
   logic       w_v;
   logic [7:0] w_final;

   assign w_cin = uio_in[0];
   assign w_sub = uio_in[1];
   assign w_acc = uio_in[2];
   assign w_sat = uio_in[3];

   // Operand select, 9-bit arithmetic, flag derivation and saturation.
   // For subtraction, bit 8 of the 9-bit difference is the borrow.
   always_comb begin
      w_x     = 8'h00;
      w_y     = 8'h00;
      w_sum   = 9'h000;
      w_raw   = 8'h00;
      w_c     = 1'b0;
      w_v     = 1'b0;
      w_final = 8'h00;

      if (w_acc) begin
         w_x = r_result;
         w_y = ui_in;
      end else begin
         w_x = {4'b0000, ui_in[3:0]};
         w_y = {4'b0000, ui_in[7:4]};
      end

      if (w_sub) begin
         w_sum = {1'b0, w_x} - {1'b0, w_y} - {8'h00, w_cin};
      end else begin
         w_sum = {1'b0, w_x} + {1'b0, w_y} + {8'h00, w_cin};
      end

      w_raw = w_sum[7:0];
      w_c   = w_sum[8];

      if (w_sub) begin
         w_v = (w_x[7] != w_y[7]) && (w_raw[7] != w_x[7]);
      end else begin
         w_v = (w_x[7] == w_y[7]) && (w_raw[7] != w_x[7]);
      end

      // Clamp only when the unsigned result left the 0..255 range.
      if (w_sat && w_c) begin
         w_final = w_sub ? 8'h00 : 8'hFF;
      end else begin
         w_final = w_raw;
      end
   end

   // Register the result and flags; Z and N describe the post-saturation R.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_result <= 8'h00;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
      end else if (ena) begin
         r_result <= w_final;
         r_c      <= w_c;
         r_v      <= w_v;
         r_z      <= (w_final == 8'h00);
         r_n      <= w_final[7];
      end
   end

   assign uo_out  = r_result;
   assign uio_out = {r_n, r_z, r_v, r_c, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_adder_team11.sv
// Directed bench for the tt_um_adder_team11 tile. Expected values are hand
// computed from the arithmetic definition and written as constants.
module tb_tt_um_adder_team11;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks;
   int errors;

   tt_um_adder_team11 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // Clock: period 10, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, sample 1 time unit later.
   task automatic step(input logic [7:0] ui, input logic [7:0] uio);
      ui_in  = ui;
      uio_in = uio;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] r, input logic [7:0] f);
      check({tag, "_r"}, uo_out, r);
      check({tag, "_f"}, uio_out, f);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      // Reset with no clock edge yet.
      #2;
      expect_out("reset", 8'h00, 8'h00);
      check("reset_oe", uio_oe, 8'hF0);
      #1;
      rst_n = 1'b0;
      ena   = 1'b1;

      // Direct add 7 + 9 + 1 = 0x11.
      step(8'h97, 8'h01);
      expect_out("dadd", 8'h11, 8'h00);
      // 0 + 0 -> Z.
      step(8'h00, 8'h00);
      expect_out("dzero", 8'h00, 8'h40);

      // Direct sub 3 - 5 = -2 -> 0xFE, C and N.
      step(8'h53, 8'h02);
      expect_out("dsub", 8'hFE, 8'h90);
      // Same with saturation -> 0x00, C and Z.
      step(8'h53, 8'h0A);
      expect_out("dsub_sat", 8'h00, 8'h50);

      // Accumulate wrap: R = 0x11, + 0xF0 = 0x101 -> 0x01, C.
      step(8'h97, 8'h01);
      expect_out("pre11a", 8'h11, 8'h00);
      step(8'hF0, 8'h04);
      expect_out("acc_wrap", 8'h01, 8'h10);
      // Same with saturation -> 0xFF, C and N.
      step(8'h97, 8'h01);
      expect_out("pre11b", 8'h11, 8'h00);
      step(8'hF0, 8'h0C);
      expect_out("acc_sat", 8'hFF, 8'h90);

      // 0xFF + 0x01 wraps to 0x00 with C and Z.
      step(8'h01, 8'h04);
      expect_out("ff_wrap", 8'h00, 8'h50);

      // Signed overflow: 0x70 + 0x10 = 0x80, V and N, no C.
      step(8'h70, 8'h04);
      expect_out("pre70", 8'h70, 8'h00);
      step(8'h10, 8'h04);
      expect_out("ovf_add", 8'h80, 8'hA0);

      // Signed overflow on sub: 0x80 - 0x01 = 0x7F, V only.
      step(8'h01, 8'h06);
      expect_out("ovf_sub", 8'h7F, 8'h20);

      // Accumulate sub with borrow-in: 0x7F - 0x7F - 1 = 0xFF, C and N.
      step(8'h7F, 8'h07);
      expect_out("acc_subcin", 8'hFF, 8'h90);

      // Hold: ena = 0 for 3 edges with changing inputs.
      ena = 1'b0;
      step(8'h12, 8'h04);
      step(8'h34, 8'h06);
      step(8'hAB, 8'h0D);
      expect_out("hold", 8'hFF, 8'h90);
      ena = 1'b1;

      // Accumulate from 0xFF: + 0x06 -> 0x05, C.
      step(8'h06, 8'h04);
      expect_out("acc_mid", 8'h05, 8'h10);

      // Asynchronous reset between edges clears immediately.
      #2;
      rst_n = 1'b1;
      #1;
      expect_out("async_rst", 8'h00, 8'h00);
      #1;
      rst_n = 1'b0;

      // First edge after release accumulates from R = 0.
      step(8'h05, 8'h04);
      expect_out("post_rst", 8'h05, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tt_um_adder_team11.md
Name: tt_um_adder_team11

Overview:
Tiny Tapeout user tile implementing a registered 8-bit adder/subtractor with an optional accumulator. Two 4-bit operands, or one 8-bit operand in accumulate mode, arrive on ui_in. Control bits arrive on uio_in[3:0]. The 8-bit result is presented on uo_out, and status flags are driven on uio_out[7:4].

Parameters:
none (all widths fixed by the tile interface)

Ports:
clk      input   1  system clock, rising-edge active
rst_n    input   1  reset; asynchronous, active-high (logic 1 resets), name kept per tile convention
ena      input   1  tile enable; 0 = hold all state
ui_in    input   8  operands: A = ui_in[3:0], B = ui_in[7:4]; full byte D = ui_in in accumulate mode
uio_in   input   8  [0] cin, [1] sub, [2] acc, [3] sat; [7:4] ignored
uo_out   output  8  result register R
uio_out  output  8  [4] C (carry/borrow), [5] V (signed overflow), [6] Z (zero), [7] N (negative); [3:0] = 0
uio_oe   output  8  constant 8'hF0

Behaviour:
- Single clock domain. Reset is asynchronous, active-high on rst_n. It clears R and the C, V, Z, N flags immediately, independent of clk.
- While reset is held, uo_out = 0x00 and uio_out = 0x00.
- uio_oe is always 0xF0. uio_out[3:0] is always 0.
- Latency is 1 cycle: inputs sampled at rising edge k appear on the outputs after edge k. All outputs come directly from registers.
- When ena = 0: R and the flags hold their values and inputs are ignored.
- Operand selection:
  - acc = 0: X = {4'b0, A}, Y = {4'b0, B}.
  - acc = 1: X = R, Y = D.
- Arithmetic (9-bit internal):
  - sub = 0: S = X + Y + cin.
  - sub = 1: S = X - Y - cin.
  - Raw result r = S[7:0].
- Carry flag C = S[8]. This is the carry-out for add, or the borrow for sub (1 when X < Y + cin).
- Overflow flag V = 8-bit two's-complement signed overflow of the operation on X and Y:
  - add: X[7] == Y[7] and r[7] != X[7].
  - sub: X[7] != Y[7] and r[7] != X[7].
- Saturation (sat = 1), unsigned, applied only when C = 1:
  - add: R <= 0xFF.
  - sub: R <= 0x00.
  - Otherwise R <= r.
  - C and V always describe the unclamped operation.
- Z = (new R == 0). N = new R[7]. Both are computed on the final, post-saturation R.
- Wrap-around: with sat = 0, results wrap modulo 256 (e.g. 0xFF + 0x01 -> 0x00, C = 1, Z = 1).
- Direct mode (acc = 0) add never exceeds 31, so C = 0 and V = 0. Direct sub can go negative (wraps, C = 1).
- Reset asserted mid-operation wins over any edge. After release, the first active edge performs a normal operation using R = 0.

Test Plan:
- Reset: assert rst_n = 1 with no clock edge -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0xF0. Release, then ena = 1.
- Direct add: ui_in = 0x97 (A = 7, B = 9), uio_in = 0x01 (cin) -> after 1 edge uo_out = 0x11, uio_out = 0x00. Then ui_in = 0x00, uio_in = 0x00 -> uo_out = 0x00, uio_out = 0x40 (Z).
- Direct sub: ui_in = 0x53 (A = 3, B = 5), uio_in = 0x02 -> uo_out = 0xFE, uio_out = 0x90 (C, N). Same with uio_in = 0x0A (sat) -> uo_out = 0x00, uio_out = 0x50 (C, Z).
- Accumulate wrap: preload R = 0x11. Then ui_in = 0xF0, uio_in = 0x04 -> uo_out = 0x01, uio_out = 0x10. Repeat from R = 0x11 with uio_in = 0x0C -> uo_out = 0xFF, uio_out = 0x90.
- Signed overflow: preload R = 0x70. Then ui_in = 0x10, uio_in = 0x04 -> uo_out = 0x80, uio_out = 0xA0 (V, N, C = 0).
- Hold and async reset: with ena = 0, change ui_in and uio_in over 3 edges -> outputs unchanged. Pulse rst_n = 1 between edges mid-accumulation -> outputs clear to 0x00 immediately.
